// File: rtl/lidar_packet_assembler.sv
// LIDAR byte-stream packet assembler.
// Frames SYNC,ANG_LO,ANG_HI,DST_LO,DST_HI,CSUM packets and checks the checksum
// and the angle range. Each good packet produces one {angle,distance} word with
// a one-cycle write strobe. Bad or timed-out packets bump a saturating error count.
module lidar_packet_assembler #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 20000,
    parameter int         MAX_ANGLE      = 36000,
    parameter int         ERR_W          = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid_in,
    output logic [31:0]      angle_distance_out,
    output logic             write_out,
    output logic [ERR_W-1:0] err_count_out,
    output logic             busy_out
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]    ANG_LIM  = 17'(MAX_ANGLE);

    // Each state names the byte the FSM is waiting for next
    typedef enum logic [2:0] {
        S_IDLE, S_ANG_LO, S_ANG_HI, S_DST_LO, S_DST_HI, S_CSUM
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      ang_q, ang_d;
    logic [15:0]      dst_q, dst_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [31:0]      ad_q, ad_d;
    logic             wr_q, wr_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       csum_calc;
    logic             pkt_ok;
    logic             err_inc;

    assign csum_calc = ang_q[7:0] ^ ang_q[15:8] ^ dst_q[7:0] ^ dst_q[15:8];
    assign pkt_ok    = (byte_in == csum_calc) && ({1'b0, ang_q} < ANG_LIM);

    // State, payload, timer and output registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            ang_q   <= '0;
            dst_q   <= '0;
            tmr_q   <= '0;
            ad_q    <= '0;
            wr_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ang_q   <= ang_d;
            dst_q   <= dst_d;
            tmr_q   <= tmr_d;
            ad_q    <= ad_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    // Next-state: a byte strobe always wins over the timeout, since it clears the timer
    always_comb begin
        state_d = state_q;
        ang_d   = ang_q;
        dst_d   = dst_q;
        tmr_d   = tmr_q;
        ad_d    = ad_q;
        wr_d    = 1'b0;
        err_inc = 1'b0;
        if (byte_valid_in) begin
            tmr_d = '0;
            case (state_q)
                S_IDLE:   if (byte_in == SYNC_BYTE) state_d = S_ANG_LO;
                S_ANG_LO: begin ang_d[7:0]  = byte_in; state_d = S_ANG_HI; end
                S_ANG_HI: begin ang_d[15:8] = byte_in; state_d = S_DST_LO; end
                S_DST_LO: begin dst_d[7:0]  = byte_in; state_d = S_DST_HI; end
                S_DST_HI: begin dst_d[15:8] = byte_in; state_d = S_CSUM;   end
                S_CSUM: begin
                    state_d = S_IDLE;
                    if (pkt_ok) begin
                        wr_d = 1'b1;
                        ad_d = {ang_q, dst_q};
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                default:  state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmr_q == TMO_LAST) begin
                state_d = S_IDLE;
                tmr_d   = '0;
                err_inc = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
        err_d = (err_inc && (err_q != '1)) ? err_q + 1'b1 : err_q;
    end

    assign angle_distance_out = ad_q;
    assign write_out          = wr_q;
    assign err_count_out      = err_q;
    assign busy_out           = (state_q != S_IDLE);

endmodule
